led_frame_sched: RTL

- Frame scheduler for the LED strip output path. It sits above the zone-to-FIFO writer, the colour-mean calculator and the LED PHY.
- Each refresh period it arms the FIFO writer, then waits for fresh zone means, and triggers FIFO fill.
- It then waits for the PHY to finish, enforces the strip latch (reset) gap, and paces the next frame.
- It reports busy, frame count and sticky error flags to the control/status logic.

---
 rtl/led_pkg.sv | 16 +
 rtl/led_frame_sched_if.sv | 28 ++
 rtl/led_cyc_timer.sv | 33 +++
 rtl/led_frame_sched.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and widths for the LED frame scheduler.
package led_pkg;

  localparam int unsigned FRAME_CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_CALC,
    S_WAIT_SEND,
    S_WAIT_PHY,
    S_LATCH,
    S_HOLD
  } sched_state_t;

endpackage

// File: rtl/led_frame_sched_if.sv
// Control/status bundle between the frame scheduler and its neighbours.
interface led_frame_sched_if;
  import led_pkg::*;

  logic                   enable;
  logic                   clr_err;
  logic                   calc_done;
  logic                   send_start;
  logic                   phy_done;
  logic                   fifo_en;
  logic                   fifo_start;
  logic                   busy;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   calc_to_err;
  logic                   phy_to_err;
  logic                   overrun_err;

  modport master (
    output enable, clr_err, calc_done, send_start, phy_done,
    input  fifo_en, fifo_start, busy, frame_cnt, calc_to_err, phy_to_err, overrun_err
  );

  modport slave (
    input  enable, clr_err, calc_done, send_start, phy_done,
    output fifo_en, fifo_start, busy, frame_cnt, calc_to_err, phy_to_err, overrun_err
  );

endinterface

// File: rtl/led_cyc_timer.sv
// Clearable up-counter that saturates at, and flags, a terminal count.
module led_cyc_timer #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] tc_i,
  output logic             tc_hit_o_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_hit_o_c = (cnt_q == tc_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (!tc_hit_o_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_frame_sched.sv
// LED strip frame scheduler: paces refreshes, sequences FIFO arm/fill and PHY,
// enforces the latch gap and keeps sticky timeout/overrun flags.
module led_frame_sched
  import led_pkg::*;
#(
  parameter int unsigned PERIOD_CYC  = 1666667,
  parameter int unsigned GAP_CYC     = 8000,
  parameter int unsigned CALC_TO_CYC = 1000000,
  parameter int unsigned PHY_TO_CYC  = 2000000,
  parameter int unsigned CNT_W       = 24
) (
  input logic              clk,
  input logic              rstn,
  led_frame_sched_if.slave bus
);

  localparam logic [CNT_W-1:0] PERIOD_TC = CNT_W'(PERIOD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_TC    = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CALC_TC   = CNT_W'(CALC_TO_CYC - 1);
  localparam logic [CNT_W-1:0] PHY_TC    = CNT_W'(PHY_TO_CYC - 1);

  sched_state_t           state_q, state_d;
  logic                   fifo_en_q, fifo_en_d;
  logic                   fifo_start_q, fifo_start_d;
  logic                   busy_q, busy_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   calc_to_err_q, calc_to_err_d;
  logic                   phy_to_err_q, phy_to_err_d;
  logic                   overrun_err_q, overrun_err_d;

  logic             per_clr_c, per_hit_c;
  logic             tmr_clr_c, tmr_hit_c;
  logic [CNT_W-1:0] tmr_tc_c;
  logic             frame_inc_c, calc_to_set_c, phy_to_set_c, overrun_set_c;

  // Period counter reads 0 in the ARM cycle, so re-arming at PERIOD_TC gives an exact period.
  assign per_clr_c = (state_d == S_ARM);
  // Gap/timeout counter restarts on every state change.
  assign tmr_clr_c = (state_d != state_q);

  led_cyc_timer #(.CNT_W(CNT_W)) u_period (
    .clk        (clk),
    .rstn       (rstn),
    .clr_i      (per_clr_c),
    .tc_i       (PERIOD_TC),
    .tc_hit_o_c (per_hit_c)
  );

  led_cyc_timer #(.CNT_W(CNT_W)) u_step (
    .clk        (clk),
    .rstn       (rstn),
    .clr_i      (tmr_clr_c),
    .tc_i       (tmr_tc_c),
    .tc_hit_o_c (tmr_hit_c)
  );

  // Terminal count of the shared timer for the current state.
  always_comb begin
    tmr_tc_c = '0;
    case (state_q)
      S_WAIT_CALC:             tmr_tc_c = CALC_TC;
      S_WAIT_SEND, S_WAIT_PHY: tmr_tc_c = PHY_TC;
      S_LATCH:                 tmr_tc_c = GAP_TC;
      default:                 tmr_tc_c = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    fifo_start_d  = 1'b0;
    frame_inc_c   = 1'b0;
    calc_to_set_c = 1'b0;
    phy_to_set_c  = 1'b0;
    overrun_set_c = 1'b0;

    case (state_q)
      S_IDLE: if (bus.enable) state_d = S_ARM;
      S_ARM:  state_d = S_WAIT_CALC;
      S_WAIT_CALC: begin
        if (bus.calc_done || tmr_hit_c) begin
          fifo_start_d  = 1'b1;
          calc_to_set_c = !bus.calc_done;
          state_d       = S_WAIT_SEND;
        end
      end
      S_WAIT_SEND: begin
        if (bus.send_start && bus.phy_done) begin
          frame_inc_c = 1'b1;
          state_d     = S_LATCH;
        end else if (bus.send_start) begin
          state_d = S_WAIT_PHY;
        end else if (tmr_hit_c) begin
          phy_to_set_c = 1'b1;
          state_d      = S_LATCH;
        end
      end
      S_WAIT_PHY: begin
        if (bus.phy_done) begin
          frame_inc_c = 1'b1;
          state_d     = S_LATCH;
        end else if (tmr_hit_c) begin
          phy_to_set_c = 1'b1;
          state_d      = S_LATCH;
        end
      end
      S_LATCH: begin
        if (tmr_hit_c) begin
          if (!bus.enable) begin
            state_d = S_IDLE;
          end else if (per_hit_c) begin
            overrun_set_c = 1'b1;
            state_d       = S_ARM;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!bus.enable)    state_d = S_IDLE;
        else if (per_hit_c) state_d = S_ARM;
      end
      default: state_d = S_IDLE;
    endcase

    fifo_en_d   = (state_q == S_ARM);
    busy_d      = (state_d != S_IDLE);
    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(frame_inc_c);
    // Clear wins over a same-cycle set.
    calc_to_err_d = !bus.clr_err && (calc_to_err_q || calc_to_set_c);
    phy_to_err_d  = !bus.clr_err && (phy_to_err_q  || phy_to_set_c);
    overrun_err_d = !bus.clr_err && (overrun_err_q || overrun_set_c);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      fifo_en_q     <= 1'b0;
      fifo_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      frame_cnt_q   <= '0;
      calc_to_err_q <= 1'b0;
      phy_to_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fifo_en_q     <= fifo_en_d;
      fifo_start_q  <= fifo_start_d;
      busy_q        <= busy_d;
      frame_cnt_q   <= frame_cnt_d;
      calc_to_err_q <= calc_to_err_d;
      phy_to_err_q  <= phy_to_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign bus.fifo_en     = fifo_en_q;
  assign bus.fifo_start  = fifo_start_q;
  assign bus.busy        = busy_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.calc_to_err = calc_to_err_q;
  assign bus.phy_to_err  = phy_to_err_q;
  assign bus.overrun_err = overrun_err_q;

endmodule
